// File: rtl/gpmc_regfile_bridge.sv
// ---------------------------------------------------------------------------
// gpmc_regfile_bridge
//
// GPMC slave that connects the BeagleBone asynchronous multiplexed 16-bit
// GPMC bus to a bank of read/write registers and read-only status words.
// Every GPMC pin is resynchronised into the OSC_FPGA domain before use.
//
// Ports:
//   OSC_FPGA   system clock, all logic on the rising edge
//   RST_N      synchronous active-low reset
//   GPMC_AD    muxed address/data, driven only during a host read
//   GPMC_CSN   chip select (active low)
//   GPMC_ADVN  address valid (active low)
//   GPMC_OEN   output enable / host read (active low)
//   GPMC_WEN   write enable (active low)
//   REG_OUT    flattened register contents, reg i at [16*i+15:16*i]
//   STATUS_IN  flattened read-only status words
//   WR_STB     one-cycle pulse, bit i on each committed write to reg i
//   ERR_CNT    saturating protocol/address error count
//
// Word map: 0..NUM_REGS-1 registers, NUM_REGS..NUM_REGS+NUM_STATUS-1 status,
// everything else reads 0 and counts as an error.
//
// Optional feature macro: GPMC_BRIDGE_ID_EN
//   When defined, word address 2^ADDR_W-1 is a read-only ID word returning
//   BRIDGE_ID; writes to it are silently ignored.
// ---------------------------------------------------------------------------
module gpmc_regfile_bridge #(
  parameter int          NUM_REGS   = 8,
  parameter int          NUM_STATUS = 4,
  parameter int          ADDR_W     = 5,
  parameter logic [15:0] BRIDGE_ID  = 16'hB0B1
) (
  input  logic                       OSC_FPGA,
  input  logic                       RST_N,
  inout  wire  [15:0]                GPMC_AD,
  input  logic                       GPMC_CSN,
  input  logic                       GPMC_ADVN,
  input  logic                       GPMC_OEN,
  input  logic                       GPMC_WEN,
  output logic [NUM_REGS*16-1:0]     REG_OUT,
  input  logic [NUM_STATUS*16-1:0]   STATUS_IN,
  output logic [NUM_REGS-1:0]        WR_STB,
  output logic [7:0]                 ERR_CNT
);

  localparam logic [31:0] ID_ADDR = 32'((1 << ADDR_W) - 1);

  // The whole word map must fit in the address field.
  if (NUM_REGS + NUM_STATUS > (1 << ADDR_W)) begin : g_map_too_big
    $error("gpmc_regfile_bridge: NUM_REGS+NUM_STATUS exceeds 2^ADDR_W");
  end

`ifdef GPMC_BRIDGE_ID_EN
  localparam bit ID_EN = 1'b1;
  // The ID word occupies the top address, so the map must stop below it.
  if (NUM_REGS + NUM_STATUS > (1 << ADDR_W) - 1) begin : g_id_overlap
    $error("gpmc_regfile_bridge: register map overlaps the ID word");
  end
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, READ, WDONE} state_t;

  state_t                    state;
  logic [3:0]                ctl_s1, ctl_s2;
  logic [1:0]                edge_q;
  logic [15:0]               ad_s1, ad_s2;
  logic [ADDR_W-1:0]         addr_q;
  logic [15:0]               rd_q;
  logic [NUM_REGS*16-1:0]    reg_q;

  logic                      s_csn, s_advn, s_oen, s_wen;
  logic                      advn_rise, wen_rise;
  logic [31:0]               addr_ext;
  logic [15:0]               rd_word;
  logic                      rd_bad, wr_bad;
  logic [NUM_REGS-1:0]       wr_sel;
  logic                      wr_commit, rd_enter, proto_err, err_evt;

  // Two-flop synchronisers. Strobes and AD share the same depth so the
  // sampled data stays aligned with the sampled strobes. A third flop on
  // ADVN and WEN gives their rising-edge detection.
  always_ff @(posedge OSC_FPGA) begin
    if (!RST_N) begin
      ctl_s1 <= 4'b1111;
      ctl_s2 <= 4'b1111;
      edge_q <= 2'b11;
      ad_s1  <= '0;
      ad_s2  <= '0;
    end else begin
      ctl_s1 <= {GPMC_CSN, GPMC_ADVN, GPMC_OEN, GPMC_WEN};
      ctl_s2 <= ctl_s1;
      edge_q <= {ctl_s2[2], ctl_s2[0]};
      ad_s1  <= GPMC_AD;
      ad_s2  <= ad_s1;
    end
  end

  assign s_csn     = ctl_s2[3];
  assign s_advn    = ctl_s2[2];
  assign s_oen     = ctl_s2[1];
  assign s_wen     = ctl_s2[0];
  assign advn_rise = s_advn & ~edge_q[1];
  assign wen_rise  = s_wen & ~edge_q[0];

  // Address decode for the latched word address: read data, write select,
  // and whether a read or write at this address is an error.
  always_comb begin
    addr_ext = 32'(addr_q);
    rd_word  = 16'h0000;
    rd_bad   = 1'b1;
    wr_bad   = 1'b1;
    wr_sel   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_ext == i) begin
        rd_word   = reg_q[16*i +: 16];
        rd_bad    = 1'b0;
        wr_bad    = 1'b0;
        wr_sel[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (addr_ext == 32'(NUM_REGS + i)) begin
        rd_word = STATUS_IN[16*i +: 16];
        rd_bad  = 1'b0;
      end
    end
    if (ID_EN && addr_ext == ID_ADDR) begin
      rd_word = BRIDGE_ID;
      rd_bad  = 1'b0;
      wr_bad  = 1'b0;
    end
  end

  // A WEN rising edge commits even when CSN rises in the same cycle, so the
  // commit test is evaluated ahead of the chip-select release.
  assign wr_commit = (state == ACCESS) && wen_rise;
  assign rd_enter  = (state == ACCESS) && !wen_rise && !s_csn && !s_oen && s_wen;
  assign proto_err = (state == ACCESS) && !wen_rise && !s_csn && !s_oen && !s_wen;
  assign err_evt   = proto_err | (rd_enter & rd_bad) | (wr_commit & wr_bad);

  // Access FSM with the register bank, write strobes and error counter.
  always_ff @(posedge OSC_FPGA) begin
    if (!RST_N) begin
      state   <= IDLE;
      addr_q  <= '0;
      rd_q    <= '0;
      reg_q   <= '0;
      WR_STB  <= '0;
      ERR_CNT <= '0;
    end else begin
      WR_STB <= '0;
      case (state)
        IDLE: begin
          if (!s_csn && !s_advn) state <= ADDR;
        end
        ADDR: begin
          if (s_csn) begin
            state <= IDLE;
          end else if (advn_rise) begin
            addr_q <= ad_s2[ADDR_W:1];
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (wr_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_sel[i]) reg_q[16*i +: 16] <= ad_s2;
            end
            WR_STB <= wr_sel;
            state  <= s_csn ? IDLE : WDONE;
          end else if (s_csn) begin
            state <= IDLE;
          end else if (proto_err) begin
            state <= WDONE;
          end else if (rd_enter) begin
            rd_q  <= rd_word;
            state <= READ;
          end
        end
        READ: begin
          if (s_csn)      state <= IDLE;
          else if (s_oen) state <= ACCESS;
        end
        WDONE: begin
          state <= s_csn ? IDLE : ACCESS;
        end
        default: state <= IDLE;
      endcase
      if (err_evt && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  assign REG_OUT = reg_q;

  // Release uses the raw pins so the bus frees as soon as the host lets go,
  // without waiting for the synchronisers.
  assign GPMC_AD = (state == READ && !GPMC_OEN && !GPMC_CSN) ? rd_q : 16'hzzzz;

endmodule

// File: tb/tb_gpmc_regfile_bridge.sv
// ---------------------------------------------------------------------------
// tb_gpmc_regfile_bridge
//
// Self-checking bench for gpmc_regfile_bridge. A host model issues GPMC
// writes and reads (directed and $urandom-driven); a word-level reference
// model predicts register contents, read data and the error count. Expected
// write strobes and read words go into queues that separate monitor
// processes pop and compare when the DUT presents them. The bus carries
// pull-ups, so a released bus reads 16'hFFFF.
// ---------------------------------------------------------------------------
module tb_gpmc_regfile_bridge;

  localparam int          NUM_REGS   = 8;
  localparam int          NUM_STATUS = 4;
  localparam int          ADDR_W     = 5;
  localparam int          NUM_WORDS  = 1 << ADDR_W;
  localparam logic [15:0] BRIDGE_ID  = 16'hB0B1;
  localparam logic [15:0] BUS_IDLE   = 16'hFFFF;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       csn, advn, oen, wen;
  logic                       host_drive;
  logic [15:0]                host_ad;
  wire  [15:0]                gpmc_ad;
  logic [NUM_REGS*16-1:0]     reg_out;
  logic [NUM_STATUS*16-1:0]   status_in;
  logic [NUM_REGS-1:0]        wr_stb;
  logic [7:0]                 err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          due;
  } wr_exp_t;

  wr_exp_t     wr_exp[$];
  logic [15:0] rd_exp[$];
  event        rd_evt;

  logic [15:0] model_regs   [NUM_REGS];
  logic [15:0] status_words [NUM_STATUS];
  int          model_err;

  assign gpmc_ad = host_drive ? host_ad : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (gpmc_ad[g]);
  end

  gpmc_regfile_bridge #(
    .NUM_REGS   (NUM_REGS),
    .NUM_STATUS (NUM_STATUS),
    .ADDR_W     (ADDR_W),
    .BRIDGE_ID  (BRIDGE_ID)
  ) dut (
    .OSC_FPGA  (clk),
    .RST_N     (rst_n),
    .GPMC_AD   (gpmc_ad),
    .GPMC_CSN  (csn),
    .GPMC_ADVN (advn),
    .GPMC_OEN  (oen),
    .GPMC_WEN  (wen),
    .REG_OUT   (reg_out),
    .STATUS_IN (status_in),
    .WR_STB    (wr_stb),
    .ERR_CNT   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: word-level view of the register map.
  function automatic logic [15:0] model_read(input int w);
    if (w < NUM_REGS) return model_regs[w];
    if (w < NUM_REGS + NUM_STATUS) return status_words[w - NUM_REGS];
`ifdef GPMC_BRIDGE_ID_EN
    if (w == NUM_WORDS - 1) return BRIDGE_ID;
`endif
    model_err = (model_err < 255) ? model_err + 1 : 255;
    return 16'h0000;
  endfunction

  function automatic bit model_write(input int w, input logic [15:0] d);
    if (w < NUM_REGS) begin
      model_regs[w] = d;
      return 1'b1;
    end
`ifdef GPMC_BRIDGE_ID_EN
    if (w == NUM_WORDS - 1) return 1'b0;
`endif
    model_err = (model_err < 255) ? model_err + 1 : 255;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 16'h0000;
    model_err = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check_value($sformatf("%s_reg%0d", tag, i), reg_out[16*i +: 16], model_regs[i]);
  endtask

  task automatic check_err(input string tag);
    check_value($sformatf("%s_err_cnt", tag), err_cnt, model_err);
  endtask

  task automatic gpmc_addr_phase(input int w);
    csn        = 1'b0;
    advn       = 1'b0;
    host_drive = 1'b1;
    host_ad    = 16'(w << 1);
    tick(4);
    advn = 1'b1;
    tick(3);
  endtask

  task automatic gpmc_write(input int w, input logic [15:0] d);
    bit is_reg;
    gpmc_addr_phase(w);
    host_ad = d;
    tick(1);
    wen = 1'b0;
    tick(4);
    wen = 1'b1;
    is_reg = model_write(w, d);
    if (is_reg) wr_exp.push_back('{idx: w, data: d, due: cyc + 3});
    tick(3);
    host_drive = 1'b0;
    csn        = 1'b1;
    tick(4);
  endtask

  // mode 0: release by OEN and check; mode 1: release by CSN and check;
  // mode 2: plain read.
  task automatic gpmc_read(input int w, input int mode);
    gpmc_addr_phase(w);
    host_drive = 1'b0;
    rd_exp.push_back(model_read(w));
    oen = 1'b0;
    tick(6);
    ->rd_evt;
    #1;
    if (mode == 1) begin
      csn = 1'b1;
      #1;
      check_value("release_on_csn", gpmc_ad, BUS_IDLE);
      tick(1);
      oen = 1'b1;
    end else begin
      oen = 1'b1;
      #1;
      if (mode == 0) check_value("release_on_oen", gpmc_ad, BUS_IDLE);
      tick(4);
      csn = 1'b1;
    end
    tick(4);
  endtask

  // Write-strobe monitor: every strobe must match the next expected write.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (wr_stb != '0) begin
        if (wr_exp.size() == 0) begin
          check_value("wr_stb_unexpected", wr_stb, 0);
        end else begin
          e = wr_exp.pop_front();
          check_value("wr_stb", wr_stb, 32'(1) << e.idx);
          check_value("wr_latency", cyc, e.due);
          check_value("wr_reg_word", reg_out[16*e.idx +: 16], e.data);
        end
      end
    end
  end

  // Read-data monitor: compares the bus while the host samples it.
  initial begin
    logic [15:0] exp;
    forever begin
      @(rd_evt);
      exp = rd_exp.pop_front();
      check_value("rd_data", gpmc_ad, exp);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    logic [15:0] d;

    rst_n      = 1'b0;
    csn        = 1'b1;
    advn       = 1'b1;
    oen        = 1'b1;
    wen        = 1'b1;
    host_drive = 1'b0;
    host_ad    = 16'h0000;
    for (int i = 0; i < NUM_STATUS; i++) status_words[i] = 16'($urandom);
    status_words[1] = 16'h1234;
    for (int i = 0; i < NUM_STATUS; i++) status_in[16*i +: 16] = status_words[i];
    model_reset();

    tick(5);
    check_regs("reset");
    check_value("reset_wr_stb", wr_stb, 0);
    check_err("reset");
    check_value("reset_bus", gpmc_ad, BUS_IDLE);
    rst_n = 1'b1;
    tick(3);

    // Basic write / read of reg 2, with both release paths.
    gpmc_write(2, 16'hA5A5);
    check_regs("wr_a5a5");
    check_err("wr_a5a5");
    gpmc_read(2, 0);
    gpmc_read(2, 1);

    // Status word read, then a write that must be ignored.
    gpmc_read(NUM_REGS + 1, 0);
    check_err("status_read");
    gpmc_write(NUM_REGS + 1, 16'hBEEF);
    check_regs("status_write");
    check_err("status_write");

    // Out-of-range read.
    gpmc_read(20, 0);
    check_err("oor_read");

`ifdef GPMC_BRIDGE_ID_EN
    gpmc_read(NUM_WORDS - 1, 0);
    gpmc_write(NUM_WORDS - 1, 16'hFFFF);
    check_regs("id_write");
    check_err("id_write");
`endif

    // Randomised traffic over the whole address space.
    for (int n = 0; n < 60; n++) begin
      w = $urandom_range(0, NUM_WORDS - 1);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) gpmc_write(w, d);
      else                           gpmc_read(w, 2);
      check_err($sformatf("rand%0d", n));
    end
    check_regs("rand_end");

    // Error counter saturation.
    repeat (300) gpmc_read(20, 2);
    check_err("saturate");

    // Reset with a read in flight: bus released at the reset edge.
    gpmc_write(2, 16'h6C3E);
    gpmc_addr_phase(2);
    host_drive = 1'b0;
    oen        = 1'b0;
    tick(6);
    check_value("pre_reset_drive", gpmc_ad, model_regs[2]);
    rst_n = 1'b0;
    tick(1);
    check_value("reset_bus_release", gpmc_ad, BUS_IDLE);
    model_reset();
    tick(1);
    check_regs("reset_mid_read");
    check_err("reset_mid_read");
    oen = 1'b1;
    csn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Reset with a write in flight: nothing may be committed.
    gpmc_addr_phase(3);
    host_ad = 16'h5A5A;
    tick(1);
    wen = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    wen = 1'b1;
    tick(4);
    host_drive = 1'b0;
    csn        = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check_regs("reset_mid_write");
    check_err("reset_mid_write");
    check_value("reset_mid_write_bus", gpmc_ad, BUS_IDLE);

    // The FSM must be back in IDLE and fully usable.
    gpmc_write(5, 16'h0F0F);
    gpmc_read(5, 0);
    check_regs("final");
    check_err("final");
    tick(4);
    check_value("pending_writes", wr_exp.size(), 0);
    check_value("pending_reads", rd_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
